// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, the shadow-stage record, and the small helpers that act on it.
package hazard_pkg;

   // Forward-select encodings. The E-stage selects reuse 0, 2 and 3.
   localparam logic [1:0] FWD_RF = 2'd0;  // regfile / pipeline register
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   // Tnew is held at a fixed width so the record type does not depend on
   // the TW parameter; TW-wide inputs are zero-extended into it (TW <= 8).
   localparam int unsigned TNEW_W = 8;

   typedef struct packed {
      logic              we;
      logic [4:0]        a3;
      logic [TNEW_W-1:0] tnew;
      logic [4:0]        rs;
      logic [4:0]        rt;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '{
      we:   1'b0,
      a3:   5'd0,
      tnew: '0,
      rs:   5'd0,
      rt:   5'd0
   };

   // Record as it moves one stage down the pipe: tnew counts down to 0.
   function automatic stage_t age_stage(input stage_t s);
      stage_t r;
      r = s;
      if (s.tnew != '0) begin
         r.tnew = s.tnew - TNEW_W'(1);
      end
      return r;
   endfunction

   // A source hits a stage when it is read, is not $0, and the stage
   // writes that same register.
   function automatic logic hits(input stage_t s, input logic use_src,
                                 input logic [4:0] src);
      return use_src && (src != 5'd0) && s.we && (s.a3 == src);
   endfunction

   // Nearest hitting stage, coded with the forward encodings
   // (FWD_RF means no stage hits).
   function automatic logic [1:0] nearest_hit(input stage_t e, input stage_t m,
                                              input stage_t w, input logic use_src,
                                              input logic [4:0] src);
      if (hits(e, use_src, src)) begin
         return FWD_E;
      end else if (hits(m, use_src, src)) begin
         return FWD_M;
      end else if (hits(w, use_src, src)) begin
         return FWD_W;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loads the operation latency on issue, then counts
// down to zero. busy is high while the count is nonzero.
module md_busy_cnt #(
   parameter int unsigned MUL_CYC = 5,
   parameter int unsigned DIV_CYC = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   localparam int unsigned CW = $clog2(DIV_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: a new issue always reloads, even over a running count.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W destination records, raises
// stalls for data and mult/div hazards, and picks forwarding sources for
// the D and E stages.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned TW      = 2,
   parameter int unsigned MUL_CYC = 5,
   parameter int unsigned DIV_CYC = 10
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [4:0]    rs_D,
   input  logic [4:0]    rt_D,
   input  logic          use_rs_D,
   input  logic          use_rt_D,
   input  logic [TW-1:0] tuse_rs_D,
   input  logic [TW-1:0] tuse_rt_D,
   input  logic [4:0]    a3_D,
   input  logic          we_D,
   input  logic [TW-1:0] tnew_D,
   input  logic          md_use_D,
   input  logic          md_start_E,
   input  logic          md_div_E,
   output logic          en_F,
   output logic          en_D,
   output logic          flush_E,
   output logic [1:0]    fwd_rs_D,
   output logic [1:0]    fwd_rt_D,
   output logic [1:0]    fwd_rs_E,
   output logic [1:0]    fwd_rt_E,
   output logic          md_busy
);

   stage_t st_e, st_m, st_w;
   stage_t st_e_d;

   logic [1:0]        hit_rs, hit_rt;
   logic [TNEW_W-1:0] tn_rs, tn_rt;
   logic [TNEW_W-1:0] tuse_rs, tuse_rt;
   logic              dstall_rs, dstall_rt;
   logic              md_stall;
   logic              stall;

   assign tuse_rs = TNEW_W'(tuse_rs_D);
   assign tuse_rt = TNEW_W'(tuse_rt_D);

   // Nearest hitting stage per D source and that stage's remaining tnew.
   always_comb begin
      hit_rs = nearest_hit(st_e, st_m, st_w, use_rs_D, rs_D);
      hit_rt = nearest_hit(st_e, st_m, st_w, use_rt_D, rt_D);
      case (hit_rs)
         FWD_E:   tn_rs = st_e.tnew;
         FWD_M:   tn_rs = st_m.tnew;
         FWD_W:   tn_rs = st_w.tnew;
         default: tn_rs = '0;
      endcase
      case (hit_rt)
         FWD_E:   tn_rt = st_e.tnew;
         FWD_M:   tn_rt = st_m.tnew;
         FWD_W:   tn_rt = st_w.tnew;
         default: tn_rt = '0;
      endcase
   end

   // Data stall when the nearest producer is not ready by the time D needs it.
   always_comb begin
      dstall_rs = (hit_rs != FWD_RF) && (tn_rs > tuse_rs);
      dstall_rt = (hit_rt != FWD_RF) && (tn_rt > tuse_rt);
   end

   md_busy_cnt #(
      .MUL_CYC (MUL_CYC),
      .DIV_CYC (DIV_CYC)
   ) u_md_busy_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (md_start_E),
      .is_div  (md_div_E),
      .busy    (md_busy)
   );

   // Stall combine; held low during reset so the pipe runs freely out of it.
   always_comb begin
      md_stall = md_use_D && (md_busy || md_start_E);
      stall    = reset_n && (dstall_rs || dstall_rt || md_stall);
      en_F     = !stall;
      en_D     = !stall;
      flush_E  = stall;
   end

   // D forward: only the nearest producer counts, and only once it is ready.
   always_comb begin
      fwd_rs_D = ((hit_rs != FWD_RF) && (tn_rs == '0)) ? hit_rs : FWD_RF;
      fwd_rt_D = ((hit_rt != FWD_RF) && (tn_rt == '0)) ? hit_rt : FWD_RF;
   end

   // E forward: E sources against M then W; a nonzero address implies use.
   always_comb begin
      fwd_rs_E = FWD_RF;
      fwd_rt_E = FWD_RF;
      if (hits(st_m, st_e.rs != 5'd0, st_e.rs)) begin
         fwd_rs_E = FWD_M;
      end else if (hits(st_w, st_e.rs != 5'd0, st_e.rs)) begin
         fwd_rs_E = FWD_W;
      end
      if (hits(st_m, st_e.rt != 5'd0, st_e.rt)) begin
         fwd_rt_E = FWD_M;
      end else if (hits(st_w, st_e.rt != 5'd0, st_e.rt)) begin
         fwd_rt_E = FWD_W;
      end
   end

   // Next E record: D's instruction, or a bubble while stalled.
   always_comb begin
      st_e_d = STAGE_BUBBLE;
      if (!stall) begin
         st_e_d.we   = we_D;
         st_e_d.a3   = a3_D;
         st_e_d.tnew = TNEW_W'(tnew_D);
         st_e_d.rs   = rs_D;
         st_e_d.rt   = rt_D;
      end
   end

   // Shadow pipeline: E <- D/bubble, M <- E, W <- M with tnew counting down.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_e <= STAGE_BUBBLE;
         st_m <= STAGE_BUBBLE;
         st_w <= STAGE_BUBBLE;
      end else begin
         st_e <= st_e_d;
         st_m <= age_stage(st_e);
         st_w <= age_stage(st_m);
      end
   end

   // Source addresses in M and W are carried for completeness but never read.
   logic unused_src;
   assign unused_src = ^{st_m.rs, st_m.rt, st_w.rs, st_w.rt};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against an age-based model.
module tb_hazard_ctrl;

   localparam int TW  = 2;
   localparam int MUL = 5;
   localparam int DIV = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [4:0]    rs_D, rt_D, a3_D;
   logic          use_rs_D, use_rt_D, we_D;
   logic [TW-1:0] tuse_rs_D, tuse_rt_D, tnew_D;
   logic          md_use_D, md_start_E, md_div_E;
   logic          en_F, en_D, flush_E, md_busy;
   logic [1:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .TW      (TW),
      .MUL_CYC (MUL),
      .DIV_CYC (DIV)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rs_D       (rs_D),
      .rt_D       (rt_D),
      .use_rs_D   (use_rs_D),
      .use_rt_D   (use_rt_D),
      .tuse_rs_D  (tuse_rs_D),
      .tuse_rt_D  (tuse_rt_D),
      .a3_D       (a3_D),
      .we_D       (we_D),
      .tnew_D     (tnew_D),
      .md_use_D   (md_use_D),
      .md_start_E (md_start_E),
      .md_div_E   (md_div_E),
      .en_F       (en_F),
      .en_D       (en_D),
      .flush_E    (flush_E),
      .fwd_rs_D   (fwd_rs_D),
      .fwd_rt_D   (fwd_rt_D),
      .fwd_rs_E   (fwd_rs_E),
      .fwd_rt_E   (fwd_rt_E),
      .md_busy    (md_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle;
      rs_D = 0; rt_D = 0; use_rs_D = 0; use_rt_D = 0;
      tuse_rs_D = 0; tuse_rt_D = 0; a3_D = 0; we_D = 0; tnew_D = 0;
      md_use_D = 0; md_start_E = 0; md_div_E = 0;
   endtask

   task automatic do_reset;
      set_idle();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " en_F"}, en_F, 1);
      chk({tag, " en_D"}, en_D, 1);
      chk({tag, " flush_E"}, flush_E, 0);
      chk({tag, " md_busy"}, md_busy, 0);
      chk({tag, " fwd_rs_D"}, fwd_rs_D, 0);
      chk({tag, " fwd_rt_D"}, fwd_rt_D, 0);
      chk({tag, " fwd_rs_E"}, fwd_rs_E, 0);
      chk({tag, " fwd_rt_E"}, fwd_rt_E, 0);
   endtask

   // ---------------- reference model ----------------
   // hist[k] is the instruction that entered E k cycles ago (k=0:E, 1:M, 2:W);
   // its remaining latency is its issue tnew minus its age.
   typedef struct {
      bit we;
      int a3;
      int tnew;
      int rs;
      int rt;
   } ins_t;

   ins_t hist[3];
   longint cyc = 0;
   longint busy_until = 0;

   function automatic int m_near(input bit u, input int src);
      if (!u || src == 0) return -1;
      for (int k = 0; k < 3; k++) begin
         if (hist[k].we && hist[k].a3 == src) return k;
      end
      return -1;
   endfunction

   function automatic int m_rem(input int k);
      return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
   endfunction

   function automatic bit m_dstall(input bit u, input int src, input int tuse);
      int k;
      k = m_near(u, src);
      return (k >= 0) && (m_rem(k) > tuse);
   endfunction

   function automatic int m_fwd_d(input bit u, input int src);
      int k;
      k = m_near(u, src);
      if (k < 0) return 0;
      return (m_rem(k) == 0) ? k + 1 : 0;
   endfunction

   function automatic int m_fwd_e(input int src);
      if (src == 0) return 0;
      for (int k = 1; k < 3; k++) begin
         if (hist[k].we && hist[k].a3 == src) return k + 1;
      end
      return 0;
   endfunction

   function automatic bit m_busy();
      return cyc < busy_until;
   endfunction

   function automatic bit m_stall();
      return m_dstall(use_rs_D, int'(rs_D), int'(tuse_rs_D)) ||
             m_dstall(use_rt_D, int'(rt_D), int'(tuse_rt_D)) ||
             (md_use_D && (m_busy() || md_start_E));
   endfunction

   task automatic m_reset;
      for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0, 0};
      busy_until = 0;
   endtask

   task automatic m_step(input bit st);
      if (md_start_E) busy_until = cyc + 1 + (md_div_E ? DIV : MUL);
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (st) hist[0] = '{0, 0, 0, 0, 0};
      else hist[0] = '{we_D, int'(a3_D), int'(tnew_D), int'(rs_D), int'(rt_D)};
      cyc++;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit p_we;
      int p_a3;
      int p_tnew;
      int age;
      bit on_rt;
      int src;
      bit use_src;
      int tuse;
      bit e_stall;
      int e_fwd;
   } vec_t;

   vec_t vecs[$];

   // Run one mult/div issue with a dependent mf* waiting in D.
   task automatic md_seq(input string tag, input bit is_div, input int exp_busy);
      int stall_cnt, busy_cnt;
      bit released;
      do_reset();
      md_start_E = 1; md_div_E = is_div; md_use_D = 1;
      @(negedge clk);
      chk({tag, " issue stall"}, flush_E, 1);
      chk({tag, " issue busy"}, md_busy, 0);
      stall_cnt = flush_E ? 1 : 0;
      busy_cnt = 0;
      released = 0;
      tick();
      md_start_E = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (md_busy) busy_cnt++;
         if (flush_E) stall_cnt++;
         else begin
            released = 1;
            break;
         end
         tick();
      end
      chk({tag, " released"}, released, 1);
      chk({tag, " busy cycles"}, busy_cnt, exp_busy);
      chk({tag, " stall cycles"}, stall_cnt, exp_busy + 1);
      chk({tag, " en_F after"}, en_F, 1);
      tick();
   endtask

   initial begin
      set_idle();
      reset_n = 1'b0;
      #2;
      chk_quiet("reset");
      tick();
      reset_n = 1'b1;

      //               we a3 tn age rt src use tuse stall fwd
      vecs.push_back('{1, 8, 2, 0, 0, 8,  1, 1,  1,    0});
      vecs.push_back('{1, 8, 2, 1, 0, 8,  1, 1,  0,    0});
      vecs.push_back('{1, 8, 2, 2, 0, 8,  1, 0,  0,    3});
      vecs.push_back('{1, 9, 1, 0, 0, 9,  1, 0,  1,    0});
      vecs.push_back('{1, 9, 1, 1, 0, 9,  1, 0,  0,    2});
      vecs.push_back('{1, 0, 2, 0, 0, 0,  1, 0,  0,    0});
      vecs.push_back('{1, 5, 0, 0, 1, 5,  1, 0,  0,    1});
      vecs.push_back('{1, 5, 3, 0, 0, 5,  1, 3,  0,    0});
      vecs.push_back('{1, 5, 3, 0, 1, 5,  1, 2,  1,    0});
      vecs.push_back('{1, 5, 0, 0, 0, 5,  0, 0,  0,    0});
      vecs.push_back('{0, 6, 2, 0, 0, 6,  1, 0,  0,    0});
      vecs.push_back('{1, 7, 1, 0, 1, 6,  1, 0,  0,    0});
      vecs.push_back('{1, 12, 3, 2, 1, 12, 1, 0, 1,    0});

      foreach (vecs[i]) begin
         do_reset();
         we_D = vecs[i].p_we; a3_D = 5'(vecs[i].p_a3); tnew_D = TW'(vecs[i].p_tnew);
         tick();
         set_idle();
         repeat (vecs[i].age) tick();
         if (vecs[i].on_rt) begin
            rt_D = 5'(vecs[i].src); use_rt_D = vecs[i].use_src; tuse_rt_D = TW'(vecs[i].tuse);
         end else begin
            rs_D = 5'(vecs[i].src); use_rs_D = vecs[i].use_src; tuse_rs_D = TW'(vecs[i].tuse);
         end
         @(negedge clk);
         chk($sformatf("vec%0d flush_E", i), flush_E, vecs[i].e_stall);
         chk($sformatf("vec%0d en_F", i), en_F, !vecs[i].e_stall);
         chk($sformatf("vec%0d fwd", i), vecs[i].on_rt ? fwd_rt_D : fwd_rs_D, vecs[i].e_fwd);
         chk($sformatf("vec%0d other fwd", i), vecs[i].on_rt ? fwd_rs_D : fwd_rt_D, 0);
      end

      // ALU back-to-back: addu $9 then beq reading $9 with tuse 0.
      do_reset();
      we_D = 1; a3_D = 9; tnew_D = 1;
      tick();
      set_idle();
      rs_D = 9; use_rs_D = 1; tuse_rs_D = 0;
      @(negedge clk);
      chk("alu stall", flush_E, 1);
      chk("alu en_D", en_D, 0);
      tick();
      @(negedge clk);
      chk("alu release", flush_E, 0);
      chk("alu fwd_rs_D", fwd_rs_D, 2);
      tick();
      set_idle();
      @(negedge clk);
      chk("alu fwd_rs_E from W", fwd_rs_E, 3);

      // Load-use: lw $8 (tnew 2) then a reader of $8 with tuse 1.
      do_reset();
      we_D = 1; a3_D = 8; tnew_D = 2;
      tick();
      set_idle();
      rs_D = 8; use_rs_D = 1; tuse_rs_D = 1;
      @(negedge clk);
      chk("lw stall", flush_E, 1);
      chk("lw en_F", en_F, 0);
      tick();
      @(negedge clk);
      chk("lw release", flush_E, 0);
      chk("lw fwd_rs_D in M", fwd_rs_D, 0);
      tick();
      set_idle();
      @(negedge clk);
      chk("lw fwd_rs_E from W", fwd_rs_E, 3);

      // E-stage forward from M: producer $3 tnew 1, consumer rt tuse 2.
      do_reset();
      we_D = 1; a3_D = 3; tnew_D = 1;
      tick();
      set_idle();
      rt_D = 3; use_rt_D = 1; tuse_rt_D = 2;
      @(negedge clk);
      chk("em no stall", flush_E, 0);
      tick();
      set_idle();
      @(negedge clk);
      chk("em fwd_rt_E from M", fwd_rt_E, 2);
      chk("em fwd_rs_E none", fwd_rs_E, 0);

      // Priority: E and M both write $5 ready; E wins.
      do_reset();
      we_D = 1; a3_D = 5; tnew_D = 0;
      tick();
      tick();
      set_idle();
      rs_D = 5; use_rs_D = 1; rt_D = 5; use_rt_D = 1;
      @(negedge clk);
      chk("prio stall", flush_E, 0);
      chk("prio fwd_rs_D", fwd_rs_D, 1);
      chk("prio fwd_rt_D", fwd_rt_D, 1);
      tick();

      md_seq("div", 1'b1, DIV);
      md_seq("mult", 1'b0, MUL);

      // Async reset in the middle of a div stall.
      do_reset();
      md_start_E = 1; md_div_E = 1; md_use_D = 1;
      tick();
      md_start_E = 0;
      tick();
      tick();
      @(negedge clk);
      chk("rst mid busy", md_busy, 1);
      chk("rst mid stall", flush_E, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_quiet("async rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post rst no stall", flush_E, 0);
      chk("post rst busy", md_busy, 0);
      tick();

      // Randomized run against the model.
      do_reset();
      m_reset();
      for (int n = 0; n < 3000; n++) begin
         bit est;
         rs_D = 5'($urandom_range(0, 3));
         rt_D = 5'($urandom_range(0, 3));
         a3_D = 5'($urandom_range(0, 3));
         use_rs_D = 1'($urandom_range(0, 1));
         use_rt_D = 1'($urandom_range(0, 1));
         we_D = 1'($urandom_range(0, 1));
         tuse_rs_D = TW'($urandom_range(0, 3));
         tuse_rt_D = TW'($urandom_range(0, 3));
         tnew_D = TW'($urandom_range(0, 3));
         md_use_D = ($urandom_range(0, 7) == 0);
         md_start_E = ($urandom_range(0, 11) == 0);
         md_div_E = 1'($urandom_range(0, 1));
         @(negedge clk);
         est = m_stall();
         chk("rnd flush_E", flush_E, est);
         chk("rnd en_F", en_F, !est);
         chk("rnd en_D", en_D, !est);
         chk("rnd md_busy", md_busy, m_busy());
         chk("rnd fwd_rs_D", fwd_rs_D, m_fwd_d(use_rs_D, int'(rs_D)));
         chk("rnd fwd_rt_D", fwd_rt_D, m_fwd_d(use_rt_D, int'(rt_D)));
         chk("rnd fwd_rs_E", fwd_rs_E, m_fwd_e(hist[0].rs));
         chk("rnd fwd_rt_E", fwd_rt_E, m_fwd_e(hist[0].rt));
         @(posedge clk);
         m_step(est);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
